// File: rtl/regfile_dump_pkg.sv
// ============================================================================
// Module      : regfile_dump_pkg
// Description : Shared state encoding and default widths for the register
//               file dump reader and the debug host bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_dump_pkg;

    localparam int DUMP_ADDR_W = 5;
    localparam int DUMP_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4
    } dumpState_t;

endpackage

`default_nettype wire

// File: rtl/regfile_dump_reader.sv
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks the register file through a spare read port and streams
//               each word to the debug host over valid/ready. Optional trailing
//               XOR checksum word when REGFILE_DUMP_CSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = DUMP_ADDR_W,
    parameter int DATA_W    = DUMP_DATA_W,
    parameter int FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              out_is_csum
);

    localparam logic [ADDR_W-1:0] C_LAST_REG  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] C_FIRST_REG = ADDR_W'(FIRST_REG);
`ifdef REGFILE_DUMP_CSUM_EN
    localparam bit C_CSUM_EN = 1'b1;
`else
    localparam bit C_CSUM_EN = 1'b0;
`endif

    dumpState_t        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_raddr;
    logic [DATA_W-1:0] r_outData;
    logic [ADDR_W-1:0] r_outIdx;
    logic              r_outValid;
    logic              r_outLast;
    logic              r_busy;
    logic              r_done;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic              r_outIsCsum;
`endif

    logic w_handshake;
    logic w_atLast;

    assign w_handshake = r_outValid && out_ready;
    // Terminal compare on the last index keeps the pointer from ever wrapping.
    assign w_atLast    = (r_ptr == C_LAST_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= C_FIRST_REG;
            r_raddr    <= '0;
            r_outData  <= '0;
            r_outIdx   <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            r_csum      <= '0;
            r_outIsCsum <= 1'b0;
`endif
        end else if (abort) begin
            // Abort outranks start and any handshake in flight; no done pulse.
            r_state    <= ST_IDLE;
            r_raddr    <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            r_outIsCsum <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                        r_ptr   <= C_FIRST_REG;
                        r_raddr <= C_FIRST_REG;
`ifdef REGFILE_DUMP_CSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end

                ST_FETCH: begin
                    r_outData  <= rf_rdata;
                    r_outIdx   <= r_ptr;
                    r_outValid <= 1'b1;
                    r_outLast  <= w_atLast && !C_CSUM_EN;
                    r_state    <= ST_SEND;
                end

                ST_SEND: begin
                    if (w_handshake) begin
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
                        r_csum     <= r_csum ^ r_outData;
`endif
                        if (w_atLast) begin
                            r_raddr <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
                            r_state     <= ST_CSUM;
                            r_outData   <= r_csum ^ r_outData;
                            r_outIdx    <= '0;
                            r_outValid  <= 1'b1;
                            r_outLast   <= 1'b1;
                            r_outIsCsum <= 1'b1;
`else
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_ptr   <= r_ptr + 1'b1;
                            r_raddr <= r_ptr + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end

`ifdef REGFILE_DUMP_CSUM_EN
                ST_CSUM: begin
                    if (w_handshake) begin
                        r_outValid  <= 1'b0;
                        r_outLast   <= 1'b0;
                        r_outIsCsum <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
`endif

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_outValid <= 1'b0;
                    r_outLast  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rf_raddr  = r_raddr;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_idx   = r_outIdx;
    assign out_last  = r_outLast;
`ifdef REGFILE_DUMP_CSUM_EN
    assign out_is_csum = r_outIsCsum;
`else
    assign out_is_csum = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Directed, table-driven bench for regfile_dump_reader with a
//               behavioural register file model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dump_reader;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_DUMP_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, out_valid, out_last, out_is_csum;
    logic [AW-1:0] rf_raddr, out_idx;
    logic [DW-1:0] rf_rdata, out_data;
    logic [DW-1:0] rf [NR];

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    assign rf_rdata = (rf_raddr == '0) ? '0 : rf[rf_raddr];

    regfile_dump_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .out_is_csum (out_is_csum)
    );

    typedef struct {
        string       name;
        int          readyMode;   // 0: always ready, 1: ready one cycle in three
        bit          spamStart;
        int          pokeAtIdx;   // -1: no datapath write
        int          pokeReg;
        logic [31:0] pokeVal;
    } scen_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] baseVal(input int i);
        return (i == 0) ? 32'h0 : 32'h1000 + i;
    endfunction

    task automatic runDump(input scen_t s);
        int          k = 0;
        int          nExp = NR + (CSUM ? 1 : 0);
        bit          stalled = 1'b0;
        bit          lastAcc = 1'b0;
        bit          finished = 1'b0;
        bit          rdy;
        logic [31:0] pd = '0;
        logic [4:0]  pi = '0;
        logic [31:0] wData, csumExp;
        logic [4:0]  wIdx;
        bit          wLast, wCsum;

        csumExp = 32'h0000_1000;  // XOR of 0x1001..0x101F
        if (s.pokeAtIdx >= 0)
            csumExp = csumExp ^ baseVal(s.pokeReg) ^ s.pokeVal;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({s.name, "_busy_after_start"}, busy, 1);
        chk({s.name, "_valid_not_yet"}, out_valid, 0);

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (lastAcc) begin
                chk({s.name, "_done_pulse"}, done, 1);
                finished = 1'b1;
            end else begin
                if (cyc == 0) chk({s.name, "_first_valid"}, out_valid, 1);
                chk({s.name, "_no_early_done"}, done, 0);
                if (stalled) begin
                    chk({s.name, "_stall_valid"}, out_valid, 1);
                    chk({s.name, "_stall_data"}, out_data, pd);
                    chk({s.name, "_stall_idx"}, out_idx, pi);
                end
                if (s.pokeAtIdx >= 0 && out_valid && out_idx == s.pokeAtIdx)
                    rf[s.pokeReg] = s.pokeVal;
                start = s.spamStart && out_valid && (out_idx < 20);
                rdy = (s.readyMode == 0) ? 1'b1 : (cyc % 3 == 2);
                out_ready = rdy;
                if (out_valid && rdy) begin
                    if (k < NR) begin
                        wIdx  = 5'(k);
                        wData = (s.pokeAtIdx >= 0 && k == s.pokeReg) ? s.pokeVal : baseVal(k);
                        wLast = !CSUM && (k == NR - 1);
                        wCsum = 1'b0;
                    end else begin
                        wIdx  = '0;
                        wData = csumExp;
                        wLast = 1'b1;
                        wCsum = 1'b1;
                    end
                    chk({s.name, "_idx"}, out_idx, wIdx);
                    chk({s.name, "_data"}, out_data, wData);
                    chk({s.name, "_last"}, out_last, wLast);
                    chk({s.name, "_is_csum"}, out_is_csum, wCsum);
                    k++;
                    lastAcc = (k == nExp);
                end
                stalled = out_valid && !rdy;
                pd = out_data;
                pi = out_idx;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (!finished) chk({s.name, "_timeout"}, 0, 1);
        chk({s.name, "_word_count"}, k, nExp);
        @(negedge clk);
        chk({s.name, "_done_one_cycle"}, done, 0);
        chk({s.name, "_idle_busy"}, busy, 0);
        chk({s.name, "_idle_raddr"}, rf_raddr, 0);
        repeat (2) @(negedge clk);
        chk({s.name, "_stays_idle"}, busy, 0);
        if (s.pokeAtIdx >= 0) rf[s.pokeReg] = baseVal(s.pokeReg);
    endtask

    initial begin
        scen_t tbl [4];
        bit    found;

        tbl[0] = '{"full",    0, 1'b0, -1, 0,  32'h0};
        tbl[1] = '{"stall",   1, 1'b0, -1, 0,  32'h0};
        tbl[2] = '{"spam",    0, 1'b1, -1, 0,  32'h0};
        tbl[3] = '{"rfwrite", 0, 1'b0,  4, 10, 32'h0000_DEAD};

        for (int i = 0; i < NR; i++) rf[i] = baseVal(i);

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_csum", out_is_csum, 0);
        chk("rst_raddr", rf_raddr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) runDump(tbl[i]);

        // Abort while idx 7 is offered and the host is ready: abort must win.
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_idx == 5'd7) begin
                abort = 1'b1;
                found = 1'b1;
            end
        end
        chk("abort_reached_idx7", found, 1);
        @(negedge clk);
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last", out_last, 0);
        chk("abort_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_stays_idle", busy, 0);
        end
        runDump(tbl[0]);

        // start and abort together in IDLE: stay idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("startabort_busy", busy, 0);
        chk("startabort_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        chk("startabort_still_idle", busy, 0);
        chk("startabort_no_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
